// File: rtl/imem_loader.sv
// Framed byte-stream loader that writes a program image into instruction memory.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing mod-256 checksum byte.
module imem_loader #(
    parameter int                    ADDR_WIDTH = 12,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                  iClk,
    input  logic                  iRstN,
    input  logic                  iStart,
    input  logic [7:0]            iByte,
    input  logic                  iByteValid,
    output logic                  oByteReady,
    output logic                  oWrEn,
    output logic [ADDR_WIDTH-1:0] oWrAddr,
    output logic [7:0]            oWrData,
    output logic                  oBusy,
    output logic                  oDone,
    output logic                  oError,
    output logic [ADDR_WIDTH:0]   oByteCount
);

    localparam int CW = ADDR_WIDTH + 1;

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_LO = 3'd1,
        S_LEN_HI = 3'd2,
        S_DATA   = 3'd3,
        S_CHECK  = 3'd4,
        S_DONE   = 3'd5,
        S_ERROR  = 3'd6
    } state_t;
    localparam state_t S_FINAL = S_CHECK;
`else
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_LO = 3'd1,
        S_LEN_HI = 3'd2,
        S_DATA   = 3'd3,
        S_DONE   = 3'd5,
        S_ERROR  = 3'd6
    } state_t;
    localparam state_t S_FINAL = S_DONE;
`endif

    state_t                state_q, state_d;
    logic                  load_q, load_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic [7:0]            len_lo_q, len_lo_d;
    logic [CW-1:0]         len_q, len_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]            wr_data_q, wr_data_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]            sum_q, sum_d;
`endif

    logic          accept;
    logic [15:0]   len_full;
    logic          len_big;
    logic [CW-1:0] cnt_inc;

    assign accept   = iByteValid && load_q;
    assign len_full = {iByte, len_lo_q};
    // Compare in 32 bits so len == 2**ADDR_WIDTH (a full image) stays legal.
    assign len_big  = {16'd0, len_full} > (32'd1 << ADDR_WIDTH);
    assign cnt_inc  = cnt_q + CW'(1);

    always_comb begin
        state_d   = state_q;
        len_lo_d  = len_lo_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_d     = sum_q;
`endif
        unique case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (iStart) begin
                    state_d  = S_LEN_LO;
                    len_lo_d = 8'd0;
                    len_d    = '0;
                    cnt_d    = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum_d    = 8'd0;
`endif
                end
            end
            S_LEN_LO: begin
                if (accept) begin
                    len_lo_d = iByte;
                    state_d  = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (accept) begin
                    len_d = CW'(len_full);
                    if (len_big) begin
                        state_d = S_ERROR;
                    end else if (len_full == 16'd0) begin
                        state_d = S_FINAL;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = BASE_ADDR + cnt_q[ADDR_WIDTH-1:0];
                    wr_data_d = iByte;
                    cnt_d     = cnt_inc;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum_d     = sum_q + iByte;
`endif
                    if (cnt_inc == len_q) begin
                        state_d = S_FINAL;
                    end
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (accept) begin
                    if (8'(sum_q + iByte) == 8'h00) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ERROR;
                    end
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake/status flags are registered from the next state.
    always_comb begin
        load_d = 1'b0;
        unique case (state_d)
            S_LEN_LO, S_LEN_HI, S_DATA: load_d = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHECK:                    load_d = 1'b1;
`endif
            default:                    load_d = 1'b0;
        endcase
        done_d  = (state_d == S_DONE);
        error_d = (state_d == S_ERROR);
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state_q   <= S_IDLE;
            load_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            len_lo_q  <= 8'd0;
            len_q     <= '0;
            cnt_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= 8'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q     <= 8'd0;
`endif
        end else begin
            state_q   <= state_d;
            load_q    <= load_d;
            done_q    <= done_d;
            error_q   <= error_d;
            len_lo_q  <= len_lo_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q     <= sum_d;
`endif
        end
    end

    assign oByteReady = load_q;
    assign oBusy      = load_q;
    assign oDone      = done_q;
    assign oError     = error_q;
    assign oWrEn      = wr_en_q;
    assign oWrAddr    = wr_addr_q;
    assign oWrData    = wr_data_q;
    assign oByteCount = cnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: two instances share one stream,
// one at BASE_ADDR 0 and one at 0xFFE to exercise address wrap.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  byt;
    logic        vld;

    logic        r0, we0, busy0, done0, err0;
    logic [11:0] wa0;
    logic [7:0]  wd0;
    logic [12:0] cnt0;
    logic        r1, we1, busy1, done1, err1;
    logic [11:0] wa1;
    logic [7:0]  wd1;
    logic [12:0] cnt1;

    int n_assert = 0;
    int n_fail   = 0;

    logic [11:0] a0_q[$];
    logic [7:0]  d0_q[$];
    logic [11:0] a1_q[$];

    always #5 clk = ~clk;

    imem_loader #(.ADDR_WIDTH(12), .BASE_ADDR(12'h000)) dut0 (
        .iClk(clk), .iRstN(rst_n), .iStart(start), .iByte(byt),
        .iByteValid(vld), .oByteReady(r0), .oWrEn(we0), .oWrAddr(wa0),
        .oWrData(wd0), .oBusy(busy0), .oDone(done0), .oError(err0),
        .oByteCount(cnt0)
    );

    imem_loader #(.ADDR_WIDTH(12), .BASE_ADDR(12'hFFE)) dut1 (
        .iClk(clk), .iRstN(rst_n), .iStart(start), .iByte(byt),
        .iByteValid(vld), .oByteReady(r1), .oWrEn(we1), .oWrAddr(wa1),
        .oWrData(wd1), .oBusy(busy1), .oDone(done1), .oError(err1),
        .oByteCount(cnt1)
    );

    always @(negedge clk) begin
        if (we0) begin
            a0_q.push_back(wa0);
            d0_q.push_back(wd0);
        end
        if (we1) a1_q.push_back(wa1);
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        a0_q.delete();
        d0_q.delete();
        a1_q.delete();
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        vld = 1'b1;
        byt = b;
        @(negedge clk);
        vld = 1'b0;
    endtask

    // Frame 04 00 13 05 10 00 (+ checksum D8); gap mode idles a cycle
    // before every byte and pulses iStart there, which must be ignored.
    task automatic send_frame(input bit gap);
        logic [7:0] fr[7];
        fr = '{8'h04, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'hD8};
`ifdef IMEM_LOADER_CHECKSUM_EN
        for (int i = 0; i < 7; i++) begin
`else
        for (int i = 0; i < 6; i++) begin
`endif
            if (gap) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            send(fr[i]);
        end
    endtask

    task automatic chk_frame(input string tag);
        logic [7:0] pl[4];
        logic [11:0] a1e[4];
        pl  = '{8'h13, 8'h05, 8'h10, 8'h00};
        a1e = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
        #1;
        chk({tag, "_done"}, done0, 1);
        chk({tag, "_busy"}, busy0, 0);
        chk({tag, "_err"}, err0, 0);
        chk({tag, "_cnt"}, cnt0, 4);
        chk({tag, "_nwr"}, a0_q.size(), 4);
        chk({tag, "_nwr1"}, a1_q.size(), 4);
        if (a0_q.size() == 4 && a1_q.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk({tag, "_addr"}, a0_q[i], i);
                chk({tag, "_data"}, d0_q[i], pl[i]);
                chk({tag, "_addr1"}, a1_q[i], a1e[i]);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        vld   = 1'b0;
        byt   = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_ready", r0, 0);
        chk("rst_wren", we0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_err", err0, 0);
        chk("rst_cnt", cnt0, 0);
        chk("rst_addr", wa0, 0);
        chk("rst_data", wd0, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic load at full rate
        do_start();
        chk("start_busy", busy0, 1);
        chk("start_ready", r0, 1);
        clr();
        send_frame(1'b0);
        chk_frame("basic");

        // Stray valid in DONE is not accepted
        vld = 1'b1;
        byt = 8'h77;
        repeat (3) @(negedge clk);
        vld = 1'b0;
        #1;
        chk("stray_ready", r0, 0);
        chk("stray_nwr", a0_q.size(), 4);
        chk("stray_cnt", cnt0, 4);

        // Gapped stream with ignored iStart pulses
        do_start();
        chk("restart_cnt", cnt0, 0);
        chk("restart_done", done0, 0);
        clr();
        send_frame(1'b1);
        chk_frame("gap");

        // Zero length
        do_start();
        clr();
        send(8'h00);
        send(8'h00);
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk("zero_pre_done", done0, 0);
        chk("zero_chk_ready", r0, 1);
        send(8'h00);
`endif
        #1;
        chk("zero_done", done0, 1);
        chk("zero_nwr", a0_q.size(), 0);
        chk("zero_cnt", cnt0, 0);

        // Oversize length 0x1001
        do_start();
        clr();
        send(8'h01);
        send(8'h10);
        #1;
        chk("big_err", err0, 1);
        chk("big_done", done0, 0);
        chk("big_busy", busy0, 0);
        chk("big_ready", r0, 0);
        chk("big_nwr", a0_q.size(), 0);

        // Restart from ERROR, short wrap frame
        do_start();
        chk("err_clear", err0, 0);
        clr();
        send(8'h03);
        send(8'h00);
        send(8'hAA);
        send(8'hBB);
        send(8'hCC);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send(8'hCF);
`endif
        #1;
        chk("wrap_done", done0, 1);
        chk("wrap_nwr", a1_q.size(), 3);
        if (a1_q.size() == 3) begin
            chk("wrap_a0", a1_q[0], 12'hFFE);
            chk("wrap_a1", a1_q[1], 12'hFFF);
            chk("wrap_a2", a1_q[2], 12'h000);
            chk("wrap_d2", d0_q[2], 8'hCC);
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Checksum good then bad
        do_start();
        clr();
        send(8'h02);
        send(8'h00);
        send(8'hAA);
        send(8'h55);
        send(8'h01);
        #1;
        chk("cs_ok_done", done0, 1);
        chk("cs_ok_err", err0, 0);
        chk("cs_ok_nwr", d0_q.size(), 2);
        do_start();
        clr();
        send(8'h02);
        send(8'h00);
        send(8'hAA);
        send(8'h55);
        send(8'h02);
        #1;
        chk("cs_bad_err", err0, 1);
        chk("cs_bad_done", done0, 0);
        chk("cs_bad_nwr", d0_q.size(), 2);
        if (d0_q.size() == 2) begin
            chk("cs_bad_d0", d0_q[0], 8'hAA);
            chk("cs_bad_d1", d0_q[1], 8'h55);
        end
`endif

        // Reset in the middle of DATA
        do_start();
        clr();
        send(8'h04);
        send(8'h00);
        send(8'h13);
        send(8'h05);
        #1;
        chk("mid_nwr", a0_q.size(), 2);
        chk("mid_cnt", cnt0, 2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", r0, 0);
        chk("mid_rst_wren", we0, 0);
        chk("mid_rst_busy", busy0, 0);
        chk("mid_rst_cnt", cnt0, 0);
        chk("mid_rst_addr", wa0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_start();
        clr();
        send_frame(1'b0);
        chk_frame("reload");

        // Full-memory image, len 0x1000
        do_start();
        clr();
        send(8'h00);
        send(8'h10);
        for (int i = 0; i < 4096; i++) begin
            send(8'(i));
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send(8'h00);
`endif
        #1;
        chk("full_done", done0, 1);
        chk("full_err", err0, 0);
        chk("full_cnt", cnt0, 13'h1000);
        chk("full_nwr", a0_q.size(), 4096);
        if (a0_q.size() == 4096 && a1_q.size() == 4096) begin
            chk("full_last_a", a0_q[4095], 12'hFFF);
            chk("full_last_d", d0_q[4095], 8'hFF);
            chk("full_d256", d0_q[256], 8'h00);
            chk("full_w_a0", a1_q[0], 12'hFFE);
            chk("full_w_a2", a1_q[2], 12'h000);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
